// File: rtl/vec_exec_unit.sv
// rtl/vec_exec_unit.sv - sequential 5-lane vector add/sub/mul/dot unit, one lane per clock.
// Optional dot-product reduction (op 11) is built only when VEC_DOT_EN is defined.
module vec_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [3:0]       vd,
  input  logic [WIDTH-1:0] va_0,
  input  logic [WIDTH-1:0] va_1,
  input  logic [WIDTH-1:0] va_2,
  input  logic [WIDTH-1:0] va_3,
  input  logic [WIDTH-1:0] va_4,
  input  logic [WIDTH-1:0] vb_0,
  input  logic [WIDTH-1:0] vb_1,
  input  logic [WIDTH-1:0] vb_2,
  input  logic [WIDTH-1:0] vb_3,
  input  logic [WIDTH-1:0] vb_4,
  output logic             busy,
  output logic             done,
  output logic             we,
  output logic [3:0]       vd_out,
  output logic [WIDTH-1:0] wd_0,
  output logic [WIDTH-1:0] wd_1,
  output logic [WIDTH-1:0] wd_2,
  output logic [WIDTH-1:0] wd_3,
  output logic [WIDTH-1:0] wd_4
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nx;
  logic [1:0]       op_r;
  logic [3:0]       vd_r;
  logic [2:0]       idx;
  logic [WIDTH-1:0] a_r  [5];
  logic [WIDTH-1:0] b_r  [5];
  logic [WIDTH-1:0] res  [5];
  logic [WIDTH-1:0] wd_r [5];
  logic [WIDTH-1:0] a_cur, b_cur, prod, lane;
  logic             op_legal, accept, last_lane;
`ifdef VEC_DOT_EN
  logic [WIDTH-1:0] acc;
`endif

`ifdef VEC_DOT_EN
  assign op_legal = 1'b1;
`else
  assign op_legal = (op != 2'b11);
`endif

  assign accept    = (state == S_IDLE) && start && op_legal;
  assign last_lane = (idx == 3'd4);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign we        = done;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_RUN;
      S_RUN:   if (last_lane) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Single shared lane ALU, fed from the captured operands.
  assign a_cur = a_r[idx];
  assign b_cur = b_r[idx];
  assign prod  = a_cur * b_cur;

  always_comb begin
    lane = prod;
    case (op_r)
      2'b00:   lane = a_cur + b_cur;
      2'b01:   lane = a_cur - b_cur;
      default: lane = prod;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_r   <= '0;
      vd_r   <= '0;
      idx    <= '0;
      vd_out <= '0;
      for (int i = 0; i < 5; i++) begin
        a_r[i]  <= '0;
        b_r[i]  <= '0;
        res[i]  <= '0;
        wd_r[i] <= '0;
      end
`ifdef VEC_DOT_EN
      acc <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_r   <= op;
            vd_r   <= vd;
            a_r[0] <= va_0;  a_r[1] <= va_1;  a_r[2] <= va_2;
            a_r[3] <= va_3;  a_r[4] <= va_4;
            b_r[0] <= vb_0;  b_r[1] <= vb_1;  b_r[2] <= vb_2;
            b_r[3] <= vb_3;  b_r[4] <= vb_4;
            idx    <= '0;
`ifdef VEC_DOT_EN
            acc    <= '0;
`endif
          end
        end
        S_RUN: begin
          res[idx] <= lane;
          idx      <= idx + 3'd1;
`ifdef VEC_DOT_EN
          acc      <= acc + prod;
`endif
          // Outputs are published all at once as the last lane completes.
          if (last_lane) begin
            vd_out <= vd_r;
            for (int i = 0; i < 4; i++) wd_r[i] <= res[i];
            wd_r[4] <= lane;
`ifdef VEC_DOT_EN
            if (op_r == 2'b11) begin
              wd_r[0] <= acc + prod;
              for (int i = 1; i < 5; i++) wd_r[i] <= '0;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign wd_0 = wd_r[0];
  assign wd_1 = wd_r[1];
  assign wd_2 = wd_r[2];
  assign wd_3 = wd_r[3];
  assign wd_4 = wd_r[4];

endmodule

// File: tb/tb_vec_exec_unit.sv
// tb/tb_vec_exec_unit.sv - self-checking bench for vec_exec_unit (table, random and corner sequences).
// Expectations for op 11 follow VEC_DOT_EN.
module tb_vec_exec_unit;

  typedef logic [4:0][31:0] vec5_t;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] vd;
    vec5_t      a;
    vec5_t      b;
    vec5_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] op;
  logic [3:0] vd;
  vec5_t      va, vb, wd;
  logic       busy, done, we;
  logic [3:0] vd_out;

  int    checks = 0;
  int    errors = 0;
  vec5_t held_wd;
  logic [3:0] held_vd;
  bit    dot_en;

  always #5 clk = ~clk;

  vec_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .vd(vd),
    .va_0(va[0]), .va_1(va[1]), .va_2(va[2]), .va_3(va[3]), .va_4(va[4]),
    .vb_0(vb[0]), .vb_1(vb[1]), .vb_2(vb[2]), .vb_3(vb[3]), .vb_4(vb[4]),
    .busy(busy), .done(done), .we(we), .vd_out(vd_out),
    .wd_0(wd[0]), .wd_1(wd[1]), .wd_2(wd[2]), .wd_3(wd[3]), .wd_4(wd[4])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec5_t v5(input logic [31:0] e0, e1, e2, e3, e4);
    vec5_t r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3; r[4] = e4;
    return r;
  endfunction

  // Reference: element-wise arithmetic modulo 2^32, dot as a plain running sum.
  function automatic vec5_t model(input logic [1:0] o, input vec5_t a, input vec5_t b);
    vec5_t r;
    logic [31:0] sum;
    sum = 0;
    r   = '0;
    for (int i = 0; i < 5; i++) begin
      case (o)
        2'd0: r[i] = a[i] + b[i];
        2'd1: r[i] = a[i] - b[i];
        2'd2: r[i] = a[i] * b[i];
        default: sum = sum + a[i] * b[i];
      endcase
    end
    if (o == 2'd3) r[0] = sum;
    return r;
  endfunction

  task automatic chk_outputs(input string tag);
    for (int i = 0; i < 5; i++) chk($sformatf("%s wd[%0d]", tag, i), wd[i], held_wd[i]);
    chk({tag, " vd_out"}, {28'd0, vd_out}, {28'd0, held_vd});
  endtask

  // Start in cycle 0, then observe cycles 1..7; leaves the bench in cycle 7 (IDLE).
  task automatic run_vec(input string tag, input logic [1:0] o, input logic [3:0] d,
                         input vec5_t a, input vec5_t b, input vec5_t e, input bit legal);
    op = o; vd = d; va = a; vb = b; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      start = 1'b0;
      chk($sformatf("%s busy c%0d", tag, c), {31'd0, busy}, {31'd0, legal && c <= 6});
      chk($sformatf("%s we c%0d", tag, c), {31'd0, we}, {31'd0, legal && c == 6});
      chk($sformatf("%s done c%0d", tag, c), {31'd0, done}, {31'd0, legal && c == 6});
      if (legal && c == 6) begin
        held_wd = e;
        held_vd = d;
      end
      chk_outputs($sformatf("%s c%0d", tag, c));
    end
  endtask

  vec_t tbl[5];

  initial begin
`ifdef VEC_DOT_EN
    dot_en = 1'b1;
`else
    dot_en = 1'b0;
`endif
    tbl[0] = '{op: 2'd0, vd: 4'd3, a: v5(1, 2, 3, 4, 5), b: v5(10, 20, 30, 40, 50),
               exp: v5(11, 22, 33, 44, 55)};
    tbl[1] = '{op: 2'd1, vd: 4'd1, a: v5(0, 0, 0, 0, 0), b: v5(1, 1, 1, 1, 1),
               exp: v5(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF)};
    tbl[2] = '{op: 2'd2, vd: 4'd2,
               a: v5(32'h10000, 32'h10000, 32'h10000, 32'h10000, 32'h10000),
               b: v5(32'h10000, 32'h10000, 32'h10000, 32'h10000, 32'h10000),
               exp: v5(0, 0, 0, 0, 0)};
    tbl[3] = '{op: 2'd2, vd: 4'd4, a: v5(2, 3, 4, 5, 6), b: v5(7, 7, 7, 7, 7),
               exp: v5(14, 21, 28, 35, 42)};
    tbl[4] = '{op: 2'd3, vd: 4'd6, a: v5(1, 2, 3, 4, 5), b: v5(1, 1, 1, 1, 1),
               exp: v5(15, 0, 0, 0, 0)};

    reset = 1'b1; start = 1'b0; op = '0; vd = '0; va = '0; vb = '0;
    held_wd = '0; held_vd = '0;
    step(); step();
    reset = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset we", {31'd0, we}, 32'd0);
    chk_outputs("reset");

    for (int t = 0; t < 5; t++)
      run_vec($sformatf("tbl%0d", t), tbl[t].op, tbl[t].vd, tbl[t].a, tbl[t].b, tbl[t].exp,
              dot_en || tbl[t].op != 2'd3);

    for (int r = 0; r < 20; r++) begin
      logic [1:0] ro;
      logic [3:0] rd;
      vec5_t ra, rb;
      ro = 2'($urandom_range(0, 3));
      rd = 4'($urandom_range(0, 15));
      for (int i = 0; i < 5; i++) begin
        ra[i] = $urandom;
        rb[i] = (r < 10) ? 32'($urandom_range(0, 255)) : $urandom;
      end
      run_vec($sformatf("rnd%0d", r), ro, rd, ra, rb, model(ro, ra, rb), dot_en || ro != 2'd3);
    end

    // Capture / ignore: operands change after acceptance, start pulses while busy.
    begin
      vec5_t na, nb;
      int    we_cnt;
      na = v5(100, 200, 300, 400, 500);
      nb = v5(7, 8, 9, 10, 11);
      op = 2'd0; vd = 4'd5; va = tbl[0].a; vb = tbl[0].b; start = 1'b1;
      we_cnt = 0;
      for (int c = 1; c <= 7; c++) begin
        step();
        start = (c == 3 || c == 6);
        if (c == 1) begin
          va = na; vb = nb; vd = 4'd9; op = 2'd1;
        end
        if (we) we_cnt++;
        if (c == 6) begin
          held_wd = tbl[0].exp;
          held_vd = 4'd5;
          chk("cap we c6", {31'd0, we}, 32'd1);
          chk_outputs("cap c6");
        end
      end
      chk("cap busy c7", {31'd0, busy}, 32'd0);
      chk("cap we count", 32'(we_cnt), 32'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("cap restart busy", {31'd0, busy}, 32'd1);
      for (int c = 9; c <= 13; c++) step();
      held_wd = model(2'd1, na, nb);
      held_vd = 4'd9;
      chk("cap2 we", {31'd0, we}, 32'd1);
      chk_outputs("cap2");
      step();
    end

    // Start held high continuously: one acceptance per 7 cycles.
    begin
      int we_cnt;
      op = 2'd2; vd = 4'd4; va = tbl[3].a; vb = tbl[3].b; start = 1'b1;
      we_cnt = 0;
      for (int c = 1; c <= 13; c++) begin
        step();
        if (we) we_cnt++;
        if (c == 6 || c == 13) chk($sformatf("hold we c%0d", c), {31'd0, we}, 32'd1);
        if (c == 7) chk("hold busy c7", {31'd0, busy}, 32'd0);
        if (c == 8) chk("hold busy c8", {31'd0, busy}, 32'd1);
      end
      start = 1'b0;
      held_wd = tbl[3].exp;
      held_vd = 4'd4;
      chk("hold we count", 32'(we_cnt), 32'd2);
      chk_outputs("hold c13");
      step();
    end

    // Reset in cycle 3 of an add: no write-back, outputs cleared.
    begin
      int we_cnt;
      op = 2'd0; vd = 4'd3; va = tbl[0].a; vb = tbl[0].b; start = 1'b1;
      we_cnt = 0;
      for (int c = 1; c <= 9; c++) begin
        step();
        start = 1'b0;
        reset = (c == 3);
        if (we) we_cnt++;
        if (c == 4) begin
          held_wd = '0;
          held_vd = '0;
          chk("rst busy c4", {31'd0, busy}, 32'd0);
          chk_outputs("rst c4");
        end
      end
      chk("rst we count", 32'(we_cnt), 32'd0);
      chk_outputs("rst c9");
    end

    run_vec("post", tbl[0].op, tbl[0].vd, tbl[0].a, tbl[0].b, tbl[0].exp, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
